// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (IF) and data (D) requesters.
// Optional build macro ARB_TIMEOUT_EN adds a BUSY-state watchdog that aborts a stuck access.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int D_STARVE = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          stall_F,
    output logic          stall_M,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          timeout_err
);
    localparam int SW = $clog2(D_STARVE + 1);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_done_q, if_done_d;
    logic          d_done_q, d_done_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          grant_i, grant_d, abort, complete;
    logic [DW-1:0] resp_data;

    // IF wins a contended grant only once D has taken D_STARVE grants in a row
    assign grant_i  = if_req && (!d_req || starve_q == SW'(D_STARVE));
    assign grant_d  = d_req && !grant_i;
    assign complete = mem_ready || abort;
    assign resp_data = abort ? '1 : (state_q == D_BUSY && mem_we_q) ? '0 : mem_rdata;

`ifdef ARB_TIMEOUT_EN
    logic [15:0] tcnt_q, tcnt_d;
    logic        terr_q, terr_d;

    // mem_ready on the final allowed cycle still completes normally
    assign abort       = !mem_ready && tcnt_q == 16'(TIMEOUT - 1);
    assign timeout_err = terr_q;

    // watchdog: counts BUSY cycles, cleared on each grant, sticky error on abort
    always_comb begin
        tcnt_d = tcnt_q;
        terr_d = terr_q;
        if (state_q == IDLE && (grant_i || grant_d))
            tcnt_d = '0;
        else if (state_q == I_BUSY || state_q == D_BUSY)
            tcnt_d = tcnt_q + 16'd1;
        if ((state_q == I_BUSY || state_q == D_BUSY) && abort)
            terr_d = 1'b1;
    end

    // watchdog registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            tcnt_q <= '0;
            terr_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            terr_q <= terr_d;
        end
    end
`else
    assign abort = 1'b0;
    // without the watchdog TIMEOUT has no effect; any legal (>=1) value gives 0
    assign timeout_err = (TIMEOUT < 1);
`endif

    // next-state: grant in IDLE, wait for memory in BUSY, one-cycle response in RESP
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = if_done_q;
        d_done_d    = d_done_q;
        starve_d    = starve_q;
        case (state_q)
            IDLE: begin
                if (grant_i || grant_d) begin
                    state_d     = grant_i ? I_BUSY : D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = grant_d && d_we;
                    mem_addr_d  = grant_i ? if_addr : d_addr;
                    mem_wdata_d = grant_i ? '0 : d_wdata;
                    // a D grant with IF waiting implies starve_q < D_STARVE, so no overflow
                    starve_d    = (grant_i || !if_req) ? '0 : starve_q + 1'b1;
                end
            end
            I_BUSY, D_BUSY: begin
                if (complete) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == I_BUSY) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = resp_data;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = resp_data;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                if_done_d  = 1'b0;
                d_done_d   = 1'b0;
                if_rdata_d = '0;
                d_rdata_d  = '0;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            starve_q    <= starve_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign busy      = state_q != IDLE;
    assign stall_F   = if_req & ~if_done_q;
    assign stall_M   = d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction model.
module tb_mem_port_arbiter;
    localparam int DS = 4;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_done, d_done, stall_F, stall_M, mem_req, mem_we, busy, timeout_err;

    int n_chk = 0, n_fail = 0;

    // model state: who owns the memory, response flags, starvation streak
    logic        m_req = 0, m_we = 0, m_ido = 0, m_ddo = 0, m_terr = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_ird = '0, m_drd = '0, mdata;
    int          owner = 0, starve = 0, nb = 0;
    int          grants[$];
    int          dgr[$];
    int          exp_g[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    mem_port_arbiter #(.AW(32), .DW(32), .D_STARVE(DS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .stall_F(stall_F), .stall_M(stall_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    // transaction model: one owner at a time, completion on ready (or watchdog), one response cycle
    always @(posedge clk) begin
        if (!reset) begin
            m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_ido = 0; m_ddo = 0;
            m_ird = 0; m_drd = 0; m_terr = 0; owner = 0; starve = 0; nb = 0;
        end else if (m_ido || m_ddo) begin
            m_ido = 0; m_ddo = 0; m_ird = 0; m_drd = 0;
        end else if (owner != 0) begin
            nb++;
            if (mem_ready || (TO_EN && nb == TO)) begin
                mdata = !mem_ready ? 32'hFFFF_FFFF : (owner == 2 && m_we) ? 32'h0 : mem_rdata;
                m_terr = m_terr | !mem_ready;
                if (owner == 1) begin m_ido = 1; m_ird = mdata; end
                else begin m_ddo = 1; m_drd = mdata; end
                m_req = 0; owner = 0;
            end
        end else if (if_req || d_req) begin
            owner   = (if_req && (!d_req || starve == DS)) ? 1 : 2;
            m_req   = 1;
            m_we    = owner == 2 && d_we;
            m_addr  = owner == 1 ? if_addr : d_addr;
            m_wdata = owner == 1 ? 32'h0 : d_wdata;
            starve  = (owner == 2 && if_req) ? starve + 1 : 0;
            nb      = 0;
            grants.push_back(owner);
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        chk("mem_req", mem_req, m_req);
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_done", if_done, m_ido);
        chk("if_rdata", if_rdata, m_ird);
        chk("d_done", d_done, m_ddo);
        chk("d_rdata", d_rdata, m_drd);
        chk("busy", busy, owner != 0 || m_ido || m_ddo);
        chk("stall_F", stall_F, if_req & ~m_ido);
        chk("stall_M", stall_M, d_req & ~m_ddo);
        chk("timeout_err", timeout_err, m_terr);
    end

    initial begin
        int cyc;
        // reset held with both requests pending
        reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_addr = 32'h10; if_addr = 32'h40;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_mem_req", mem_req, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", {if_done, d_done}, 0);
        end
        reset = 1'b1;
        tick();
        chk("rst_release_req", mem_req, 1);
        chk("rst_release_addr", mem_addr, 32'h10);
        do_reset();

        // IF read, memory ready immediately
        if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h2002000A;
        #1 chk("if_c0_stall", stall_F, 1);
        tick();
        chk("if_c1_req", mem_req, 1);
        chk("if_c1_addr", mem_addr, 32'h40);
        chk("if_c1_stall", stall_F, 1);
        tick();
        chk("if_c2_done", if_done, 1);
        chk("if_c2_rdata", if_rdata, 32'h2002000A);
        chk("if_c2_stall", stall_F, 0);
        if_req = 1'b0; mem_ready = 1'b0;
        tick();
        chk("if_c3_idle", busy, 0);
        chk("if_c3_rdata", if_rdata, 0);

        // D write with a three-cycle memory wait
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dw_req", mem_req, 1);
            chk("dw_we", mem_we, 1);
            chk("dw_addr", mem_addr, 32'h80);
            chk("dw_wdata", mem_wdata, 32'h1234);
            chk("dw_nodone", d_done, 0);
        end
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("dw_done", d_done, 1);
        chk("dw_rdata", d_rdata, 0);
        chk("dw_req_drop", mem_req, 0);
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        tick();
        chk("dw_done_end", d_done, 0);

        // contention: both requests held, expect D x4 then I
        do_reset();
        grants.delete(); dgr.delete();
        if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_ready = 1'b1;
        cyc = 0;
        for (int i = 0; i < 100 && dgr.size() < 10; i++) begin
            tick();
            if (mem_req && !cyc[0]) dgr.push_back(mem_addr == 32'h100 ? 1 : 2);
            cyc = {31'b0, mem_req};
        end
        chk("grant_count", dgr.size(), 10);
        for (int k = 0; k < 10; k++) begin
            if (k < grants.size()) chk($sformatf("model_grant%0d", k), grants[k], exp_g[k]);
            if (k < dgr.size()) chk($sformatf("dut_grant%0d", k), dgr[k], exp_g[k]);
        end

        // reset in the middle of a D access
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        tick();
        chk("rm_busy", busy, 1);
        tick();
        reset = 1'b0;
        tick();
        chk("rm_req", mem_req, 0);
        chk("rm_idle", busy, 0);
        reset = 1'b1; d_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rm_nodone", d_done, 0);
        end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (if_req && m_ido) begin if_req = 1'($urandom_range(0, 1)); if_addr = $urandom; end
            else if (!if_req && $urandom_range(0, 3) == 0) begin if_req = 1'b1; if_addr = $urandom; end
            if (d_req && m_ddo) begin
                d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end else if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            end
            mem_ready = $urandom_range(0, 2) == 0;
            mem_rdata = $urandom;
            reset = $urandom_range(0, 299) != 0;
            tick();
        end

`ifdef ARB_TIMEOUT_EN
        // watchdog abort with memory never ready
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        cyc = 0;
        for (int i = 0; i < 40 && !d_done; i++) begin
            tick();
            if (mem_req) cyc++;
        end
        chk("to_cycles", cyc, TO);
        chk("to_done", d_done, 1);
        chk("to_rdata", d_rdata, 32'hFFFF_FFFF);
        chk("to_err", timeout_err, 1);
        d_req = 1'b0;
        tick(); tick();
        chk("to_sticky", timeout_err, 1);
        do_reset();
        chk("to_clear", timeout_err, 0);
`else
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        for (int i = 0; i < 20; i++) tick();
        chk("no_to_waiting", mem_req, 1);
        chk("no_to_err", timeout_err, 0);
        do_reset();
`endif
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
